// File: rtl/rom_fetch_arbiter_if.sv
// Request/response port of the ROM fetch arbiter: one instance per requester.
// The master drives req/addr and holds them until gnt; the slave answers one cycle later.
interface rom_fetch_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata,
        output err
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Shares the instruction ROM read port between the IF stage and a debug/loader port.
// Fetch has priority; a starvation counter forces a debug grant after StarveMax denials.
module rom_fetch_arbiter #(
    parameter int unsigned Depth     = 128,
    parameter int unsigned StarveMax = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    rom_fetch_arbiter_if.slave fetch_io,
    rom_fetch_arbiter_if.slave dbg_io,
    output logic               rom_ce_o,
    output logic [31:0]        rom_addr_o,
    input  logic [31:0]        rom_inst_i
);

    localparam int unsigned CntW = (StarveMax > 1) ? $clog2(StarveMax) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(StarveMax - 1);
    localparam logic [CntW-1:0] CntSat  = {CntW{1'b1}};

    typedef enum logic [0:0] {StFetchPri, StDbgForced} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] starve_q, starve_d;

    logic        if_gnt, dbg_gnt, any_gnt;
    logic [31:0] gnt_addr;
    logic [31:0] gnt_idx;
    logic        acc_err;
    logic [31:0] rsp_rdata;

    logic        if_rv_q, dbg_rv_q;
    logic [31:0] if_rdata_q, dbg_rdata_q;
    logic        if_err_q, dbg_err_q;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if_gnt   = 1'b0;
        dbg_gnt  = 1'b0;

        // Grants are suppressed while reset is asserted.
        if (rst_ni) begin
            unique case (state_q)
                StFetchPri: begin
                    if (fetch_io.req && !flush_i) begin
                        if_gnt = 1'b1;
                    end else if (dbg_io.req) begin
                        dbg_gnt = 1'b1;
                    end
                end
                StDbgForced: dbg_gnt = 1'b1;
                default: ;
            endcase
        end

        if (!dbg_io.req || dbg_gnt) begin
            starve_d = '0;
        end else if (starve_q != CntSat) begin
            starve_d = starve_q + 1'b1;
        end

        if (state_q == StDbgForced) begin
            state_d = StFetchPri;
        end else if (dbg_io.req && !dbg_gnt && starve_q == CntLast) begin
            state_d = StDbgForced;
        end
    end

    always_comb begin
        any_gnt    = if_gnt | dbg_gnt;
        gnt_addr   = if_gnt ? fetch_io.addr : dbg_io.addr;
        gnt_idx    = {2'b00, gnt_addr[31:2]};
        acc_err    = (gnt_addr[1:0] != 2'b00) || (gnt_idx >= 32'(Depth));
        rom_ce_o   = any_gnt & ~acc_err;
        rom_addr_o = rom_ce_o ? gnt_idx : 32'h0;
        rsp_rdata  = acc_err ? 32'h0 : rom_inst_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StFetchPri;
            starve_q    <= '0;
            if_rv_q     <= 1'b0;
            dbg_rv_q    <= 1'b0;
            if_rdata_q  <= '0;
            dbg_rdata_q <= '0;
            if_err_q    <= 1'b0;
            dbg_err_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if_rv_q  <= if_gnt;
            dbg_rv_q <= dbg_gnt;
            if (if_gnt) begin
                if_rdata_q <= rsp_rdata;
                if_err_q   <= acc_err;
            end
            if (dbg_gnt) begin
                dbg_rdata_q <= rsp_rdata;
                dbg_err_q   <= acc_err;
            end
        end
    end

    // A response pending when reset arrives is dropped rather than presented.
    assign fetch_io.gnt    = if_gnt;
    assign fetch_io.rvalid = if_rv_q & ~flush_i & rst_ni;
    assign fetch_io.rdata  = if_rdata_q;
    assign fetch_io.err    = if_err_q;

    assign dbg_io.gnt    = dbg_gnt;
    assign dbg_io.rvalid = dbg_rv_q & rst_ni;
    assign dbg_io.rdata  = dbg_rdata_q;
    assign dbg_io.err    = dbg_err_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed self-checking bench for rom_fetch_arbiter: ROM word i holds 0xA0000000 + i.
module tb_rom_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] rom_mem [0:127];

    int checks = 0;
    int errors = 0;

    rom_fetch_arbiter_if fetch_bus ();
    rom_fetch_arbiter_if dbg_bus ();

    rom_fetch_arbiter #(
        .Depth     (128),
        .StarveMax (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .fetch_io   (fetch_bus),
        .dbg_io     (dbg_bus),
        .rom_ce_o   (rom_ce),
        .rom_addr_o (rom_addr),
        .rom_inst_i (rom_inst)
    );

    always #5 clk = ~clk;

    assign rom_inst = rom_mem[rom_addr[6:0]];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom_mem[i] = 32'hA000_0000 + 32'(i);

        rst_n         = 1'b0;
        flush         = 1'b0;
        fetch_bus.req  = 1'b0;
        fetch_bus.addr = 32'h0;
        dbg_bus.req    = 1'b0;
        dbg_bus.addr   = 32'h0;

        // Reset state, with a request present to show grants stay low.
        next_cycle();
        fetch_bus.req = 1'b1;
        next_cycle();
        chk1("rst_if_gnt", fetch_bus.gnt, 1'b0);
        chk1("rst_rom_ce", rom_ce, 1'b0);
        chk1("rst_if_rvalid", fetch_bus.rvalid, 1'b0);
        chk32("rst_if_rdata", fetch_bus.rdata, 32'h0);
        chk1("rst_dbg_rvalid", dbg_bus.rvalid, 1'b0);
        fetch_bus.req = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        // 1: back-to-back fetches of words 0..3.
        for (int i = 0; i < 4; i++) begin
            fetch_bus.req  = 1'b1;
            fetch_bus.addr = 32'(i * 4);
            #1;
            chk1("t1_if_gnt", fetch_bus.gnt, 1'b1);
            chk1("t1_rom_ce", rom_ce, 1'b1);
            chk32("t1_rom_addr", rom_addr, 32'(i));
            if (i > 0) begin
                chk1("t1_if_rvalid", fetch_bus.rvalid, 1'b1);
                chk32("t1_if_rdata", fetch_bus.rdata, 32'hA000_0000 + 32'(i - 1));
            end
            next_cycle();
        end
        fetch_bus.req = 1'b0;
        #1;
        chk1("t1_last_rvalid", fetch_bus.rvalid, 1'b1);
        chk32("t1_last_rdata", fetch_bus.rdata, 32'hA000_0003);
        chk1("t1_idle_gnt", fetch_bus.gnt, 1'b0);
        next_cycle();
        chk1("t1_rvalid_drop", fetch_bus.rvalid, 1'b0);
        chk32("t1_rdata_hold", fetch_bus.rdata, 32'hA000_0003);

        // 2: both requesting; debug forced on cycle 5 only.
        fetch_bus.req  = 1'b1;
        fetch_bus.addr = 32'h0;
        dbg_bus.req    = 1'b1;
        dbg_bus.addr   = 32'h8;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            #1;
            chk1("t2_dbg_gnt", dbg_bus.gnt, cyc == 5);
            chk1("t2_if_gnt", fetch_bus.gnt, cyc != 5);
            chk1("t2_dbg_rvalid", dbg_bus.rvalid, cyc == 6);
            if (cyc == 5) chk32("t2_rom_addr", rom_addr, 32'h2);
            if (cyc == 6) chk32("t2_dbg_rdata", dbg_bus.rdata, 32'hA000_0002);
            next_cycle();
        end
        fetch_bus.req = 1'b0;
        dbg_bus.req   = 1'b0;
        next_cycle();

        // 3: misaligned fetch and out-of-range debug read, then a valid last word.
        fetch_bus.req  = 1'b1;
        fetch_bus.addr = 32'h2;
        #1;
        chk1("t3_if_gnt", fetch_bus.gnt, 1'b1);
        chk1("t3_if_rom_ce", rom_ce, 1'b0);
        chk32("t3_if_rom_addr", rom_addr, 32'h0);
        next_cycle();
        fetch_bus.req = 1'b0;
        chk1("t3_if_rvalid", fetch_bus.rvalid, 1'b1);
        chk1("t3_if_err", fetch_bus.err, 1'b1);
        chk32("t3_if_rdata", fetch_bus.rdata, 32'h0);
        dbg_bus.req  = 1'b1;
        dbg_bus.addr = 32'h200;
        #1;
        chk1("t3_dbg_gnt", dbg_bus.gnt, 1'b1);
        chk1("t3_dbg_rom_ce", rom_ce, 1'b0);
        next_cycle();
        chk1("t3_dbg_rvalid", dbg_bus.rvalid, 1'b1);
        chk1("t3_dbg_err", dbg_bus.err, 1'b1);
        chk32("t3_dbg_rdata", dbg_bus.rdata, 32'h0);
        dbg_bus.addr = 32'h1FC;
        #1;
        chk1("t3_dbg127_rom_ce", rom_ce, 1'b1);
        chk32("t3_dbg127_rom_addr", rom_addr, 32'd127);
        next_cycle();
        dbg_bus.req = 1'b0;
        chk1("t3_dbg127_err", dbg_bus.err, 1'b0);
        chk32("t3_dbg127_rdata", dbg_bus.rdata, 32'hA000_007F);
        next_cycle();

        // 4: flush blocks the fetch grant, then masks a fetch response.
        flush          = 1'b1;
        fetch_bus.req  = 1'b1;
        fetch_bus.addr = 32'h10;
        dbg_bus.req    = 1'b1;
        dbg_bus.addr   = 32'h14;
        #1;
        chk1("t4_flush_if_gnt", fetch_bus.gnt, 1'b0);
        chk1("t4_flush_dbg_gnt", dbg_bus.gnt, 1'b1);
        chk32("t4_flush_rom_addr", rom_addr, 32'h5);
        next_cycle();
        flush       = 1'b0;
        dbg_bus.req = 1'b0;
        #1;
        chk1("t4_dbg_rvalid", dbg_bus.rvalid, 1'b1);
        chk32("t4_dbg_rdata", dbg_bus.rdata, 32'hA000_0005);
        chk1("t4_if_gnt", fetch_bus.gnt, 1'b1);
        chk32("t4_if_rom_addr", rom_addr, 32'h4);
        next_cycle();
        fetch_bus.req = 1'b0;
        flush         = 1'b1;
        #1;
        chk1("t4_masked_rvalid", fetch_bus.rvalid, 1'b0);
        chk1("t4_dbg_unaffected", dbg_bus.rvalid, 1'b0);
        next_cycle();
        flush = 1'b0;
        #1;
        chk1("t4_no_late_rvalid", fetch_bus.rvalid, 1'b0);
        next_cycle();

        // 5: reset the cycle after a grant drops the response.
        fetch_bus.req  = 1'b1;
        fetch_bus.addr = 32'h8;
        #1;
        chk1("t5_if_gnt", fetch_bus.gnt, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk1("t5_rst_rvalid", fetch_bus.rvalid, 1'b0);
        chk1("t5_rst_gnt", fetch_bus.gnt, 1'b0);
        chk1("t5_rst_rom_ce", rom_ce, 1'b0);
        next_cycle();
        rst_n         = 1'b1;
        fetch_bus.req = 1'b0;
        #1;
        chk1("t5_post_rvalid", fetch_bus.rvalid, 1'b0);
        chk32("t5_post_rdata", fetch_bus.rdata, 32'h0);
        chk1("t5_post_err", fetch_bus.err, 1'b0);
        chk32("t5_post_dbg_rdata", dbg_bus.rdata, 32'h0);
        chk1("t5_post_dbg_err", dbg_bus.err, 1'b0);
        next_cycle();
        // Counter restarts from zero: debug forced on the fifth shared cycle again.
        fetch_bus.req  = 1'b1;
        fetch_bus.addr = 32'h0;
        dbg_bus.req    = 1'b1;
        dbg_bus.addr   = 32'hC;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            #1;
            chk1("t5_starve_dbg_gnt", dbg_bus.gnt, cyc == 5);
            next_cycle();
        end
        fetch_bus.req = 1'b0;
        dbg_bus.req   = 1'b0;
        next_cycle();
        next_cycle();

        // 6: idle for ten cycles.
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            chk1("t6_rom_ce", rom_ce, 1'b0);
            chk1("t6_if_gnt", fetch_bus.gnt, 1'b0);
            chk1("t6_dbg_gnt", dbg_bus.gnt, 1'b0);
            chk1("t6_if_rvalid", fetch_bus.rvalid, 1'b0);
            chk1("t6_dbg_rvalid", dbg_bus.rvalid, 1'b0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
